mul_pipe_param: RTL and testbench
=================================

Name: mul_pipe_param

Overview:
- Parametrised, fully pipelined integer multiplier for the integer execute cluster; next generation of the fixed 32-bit, 8-stage multiply unit.
- Generalised in data width (XLEN 32/64), stage count and RV64 word ops (MULW).
- Freezes in place on writeback stall instead of dropping in-flight ops.
- Applies sequence-number branch flush at every stage and on the output register.

Parameters:
- XLEN, 32, operand/result width; 32 or 64.
- NUM_STAGES, 8, partial-product stages; must divide XLEN.
- SQN_W, 6, sequence-number width.
- TAG_W, 6, physical destination tag width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  unit enable; IN_valid ignored when low.
- IN_wbStall  in  1  writeback port stall; freezes whole pipeline.
- IN_branchTaken  in  1  branch mispredict flush this cycle.
- IN_branchSqN  in  SQN_W  sqN of mispredicted branch.
- IN_valid  in  1  op presented.
- IN_op  in  2  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
- IN_word  in  1  W variant (MULW); legal only with XLEN=64 and IN_op=0.
- IN_srcA  in  XLEN  rs1.
- IN_srcB  in  XLEN  rs2.
- IN_tagDst  in  TAG_W  destination tag.
- IN_nmDst  in  5  architectural destination.
- IN_sqN  in  SQN_W  op sequence number.
- OUT_ready  out  1  = !IN_wbStall; op accepted when IN_valid & en & OUT_ready.
- OUT_wbReq  out  1  writeback request; valid bit of last internal stage.
- OUT_valid  out  1  result valid.
- OUT_result  out  XLEN  result.
- OUT_tagDst  out  TAG_W  passthrough.
- OUT_nmDst  out  5  passthrough.
- OUT_sqN  out  SQN_W  passthrough.

Behaviour:
- Reset (rst=0, async): all stage valid bits 0; OUT_valid=0; OUT_result, OUT_tagDst, OUT_nmDst, OUT_sqN = 0. Reset mid-operation discards all in-flight ops. No op emerges after release until newly accepted.
- Kill predicate for an op with sqN s: IN_branchTaken && $signed(s - IN_branchSqN) > 0, using SQN_W-bit wrap-around subtraction. Equal sqN (the branch itself) is not killed.
- Accept: accepted op that is not killed enters stage 0. Otherwise stage 0 valid=0.
- Stage 0 captures:
  - resSign: MUL/MULH = A[msb]^B[msb]; MULHSU = A[msb]; MULHU = 0.
  - Magnitudes: |A| when A is signed; |B| only for MUL/MULH.
  - Word mode: operands are the low 32 bits treated as signed.
  - Clear accumulator (2*XLEN bits).
  - Record hi-select (op != 0).
- Stage i (0..NUM_STAGES-1): acc += (magA * magB[BITS*i +: BITS]) << (BITS*i), BITS = XLEN/NUM_STAGES.
  - Advance only when !IN_wbStall.
  - Killed ops clear their valid bit while advancing.
- Output register, loaded when !IN_wbStall:
  - p = resSign ? -acc : acc.
  - Result: hi-select -> p[2*XLEN-1:XLEN]; else p[XLEN-1:0]; word -> sign-extend p[31:0].
  - OUT_valid = last-stage valid & !kill.
- Latency: op accepted at edge t is presented with OUT_valid=1 after edge t+NUM_STAGES+1, absent stalls. Each stall cycle adds exactly one cycle.
- Throughput: one op/cycle; no bubbles inserted.
- Stall:
  - All stage registers and output registers hold.
  - Flush still clears valid bits of killed ops during stall, without moving data.
  - Inputs not accepted.
- Simultaneous accept + flush: the incoming op is also tested against the kill predicate.
- Sign corner: magnitude of most-negative value is 2^(XLEN-1), held unsigned. No overflow.

Test Plan:
- XLEN=32, NUM_STAGES=8, MUL A=7, B=0xFFFFFFFD -> OUT_result=0xFFFFFFEB, OUT_valid exactly 9 cycles after accept.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- Back-to-back 8 ops, IN_wbStall high for 3 cycles mid-stream -> OUT_ready low those cycles; all 8 results in order, none lost or duplicated; last result 3 cycles later than unstalled.
- Ops sqN 5, 6, 7 in flight; flush with branchSqN=6 -> sqN 5 and 6 write back, 7 never asserts OUT_valid. Repeat with sqN 62, 63, 0 and branchSqN=63 -> 0 killed (wrap).
- XLEN=64, MULW A=0x00000000_40000000, B=4 -> 0x00000000_00000000; A=0x7FFFFFFF, B=2 -> 0xFFFFFFFF_FFFFFFFE.
- rst asserted asynchronously mid-clock with 5 ops in flight -> OUT_valid=0 immediately; no result emerges after release.

Source files
------------

// File: rtl/mul_pipe_param.sv
// Parametrised, fully pipelined integer multiplier (MUL/MULH/MULHSU/MULHU, MULW on RV64).
// The whole pipe freezes on writeback stall; sequence-number flush is applied at every stage.
module mul_pipe_param #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_STAGES = 8,
  parameter int unsigned SQN_W      = 6,
  parameter int unsigned TAG_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             IN_wbStall,
  input  logic             IN_branchTaken,
  input  logic [SQN_W-1:0] IN_branchSqN,
  input  logic             IN_valid,
  input  logic [1:0]       IN_op,
  input  logic             IN_word,
  input  logic [XLEN-1:0]  IN_srcA,
  input  logic [XLEN-1:0]  IN_srcB,
  input  logic [TAG_W-1:0] IN_tagDst,
  input  logic [4:0]       IN_nmDst,
  input  logic [SQN_W-1:0] IN_sqN,
  output logic             OUT_ready,
  output logic             OUT_wbReq,
  output logic             OUT_valid,
  output logic [XLEN-1:0]  OUT_result,
  output logic [TAG_W-1:0] OUT_tagDst,
  output logic [4:0]       OUT_nmDst,
  output logic [SQN_W-1:0] OUT_sqN
);
  localparam int unsigned BITS  = XLEN / NUM_STAGES;
  localparam int unsigned ACC_W = 2 * XLEN;
  localparam bit          WORD_OK = (XLEN == 64);

  typedef struct packed {
    logic             valid;
    logic [SQN_W-1:0] sqn;
    logic [TAG_W-1:0] tag;
    logic [4:0]       nm;
    logic             res_sign;
    logic             hi_sel;
    logic             word;
    logic [XLEN-1:0]  mag_a;
    logic [XLEN-1:0]  mag_b;
    logic [ACC_W-1:0] acc;
  } stage_t;

  // Register k holds an op after k partial products have been accumulated.
  stage_t stg_q [NUM_STAGES+1];
  stage_t stg_d [NUM_STAGES+1];
  stage_t in_stg;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [4:0]       out_nm_q, out_nm_d;
  logic [SQN_W-1:0] out_sqn_q, out_sqn_d;

  logic [XLEN-1:0]  op_a, op_b;
  logic             a_neg, b_neg, word_c;
  logic [ACC_W-1:0] prod_c;
  logic [XLEN-1:0]  res_c;

  // Younger than the mispredicted branch under wrap-around sequence numbers.
  function automatic logic is_killed(input logic [SQN_W-1:0] sqn, input logic taken,
                                     input logic [SQN_W-1:0] br_sqn);
    logic [SQN_W-1:0] diff;
    diff = sqn - br_sqn;
    return taken && !diff[SQN_W-1] && (diff != '0);
  endfunction

  always_comb begin
    word_c = WORD_OK && IN_word;
    op_a   = IN_srcA;
    op_b   = IN_srcB;
    if (word_c) begin
      op_a = XLEN'($signed(IN_srcA[31:0]));
      op_b = XLEN'($signed(IN_srcB[31:0]));
    end
    a_neg = (IN_op != 2'd3) && op_a[XLEN-1];
    b_neg = (IN_op[1] == 1'b0) && op_b[XLEN-1];

    in_stg          = '0;
    in_stg.valid    = IN_valid && en && !IN_wbStall &&
                      !is_killed(IN_sqN, IN_branchTaken, IN_branchSqN);
    in_stg.sqn      = IN_sqN;
    in_stg.tag      = IN_tagDst;
    in_stg.nm       = IN_nmDst;
    in_stg.res_sign = a_neg ^ b_neg;
    in_stg.hi_sel   = (IN_op != 2'd0);
    in_stg.word     = word_c;
    in_stg.mag_a    = a_neg ? -op_a : op_a;
    in_stg.mag_b    = b_neg ? -op_b : op_b;
  end

  always_comb begin
    for (int k = 0; k <= NUM_STAGES; k++) begin
      stg_d[k]       = stg_q[k];
      stg_d[k].valid = stg_q[k].valid && !is_killed(stg_q[k].sqn, IN_branchTaken, IN_branchSqN);
    end
    if (!IN_wbStall) begin
      stg_d[0] = in_stg;
      for (int k = 0; k < NUM_STAGES; k++) begin
        stg_d[k+1]       = stg_q[k];
        stg_d[k+1].valid = stg_q[k].valid &&
                           !is_killed(stg_q[k].sqn, IN_branchTaken, IN_branchSqN);
        stg_d[k+1].acc   = stg_q[k].acc +
                           ((ACC_W'(stg_q[k].mag_a) * ACC_W'(stg_q[k].mag_b[BITS*k +: BITS]))
                            << (BITS*k));
      end
    end
  end

  // Sign fix-up and result selection from the last accumulation register.
  always_comb begin
    prod_c = stg_q[NUM_STAGES].res_sign ? -stg_q[NUM_STAGES].acc : stg_q[NUM_STAGES].acc;
    res_c  = stg_q[NUM_STAGES].hi_sel ? prod_c[ACC_W-1:XLEN] : prod_c[XLEN-1:0];
    if (stg_q[NUM_STAGES].word) res_c = XLEN'($signed(prod_c[31:0]));

    out_valid_d  = out_valid_q && !is_killed(out_sqn_q, IN_branchTaken, IN_branchSqN);
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_nm_d     = out_nm_q;
    out_sqn_d    = out_sqn_q;
    if (!IN_wbStall) begin
      out_valid_d  = stg_q[NUM_STAGES].valid &&
                     !is_killed(stg_q[NUM_STAGES].sqn, IN_branchTaken, IN_branchSqN);
      out_result_d = res_c;
      out_tag_d    = stg_q[NUM_STAGES].tag;
      out_nm_d     = stg_q[NUM_STAGES].nm;
      out_sqn_d    = stg_q[NUM_STAGES].sqn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k <= NUM_STAGES; k++) stg_q[k] <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_nm_q     <= '0;
      out_sqn_q    <= '0;
    end else begin
      for (int k = 0; k <= NUM_STAGES; k++) stg_q[k] <= stg_d[k];
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_nm_q     <= out_nm_d;
      out_sqn_q    <= out_sqn_d;
    end
  end

  assign OUT_ready  = !IN_wbStall;
  assign OUT_wbReq  = stg_q[NUM_STAGES].valid;
  assign OUT_valid  = out_valid_q;
  assign OUT_result = out_result_q;
  assign OUT_tagDst = out_tag_q;
  assign OUT_nmDst  = out_nm_q;
  assign OUT_sqN    = out_sqn_q;

endmodule

// File: tb/tb_mul_pipe_param.sv
// Directed bench for mul_pipe_param: a 32-bit and a 64-bit instance share most stimulus.
module tb_mul_pipe_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, stall, br_taken, v32, v64, word;
  logic [5:0]  br_sqn, tag, sqn;
  logic [1:0]  op;
  logic [4:0]  nm;
  logic [63:0] a, b;

  logic        r32_ready, r32_wbreq, r32_valid;
  logic [31:0] r32_res;
  logic [5:0]  r32_tag, r32_sqn;
  logic [4:0]  r32_nm;
  logic        r64_ready, r64_wbreq, r64_valid;
  logic [63:0] r64_res;
  logic [5:0]  r64_tag, r64_sqn;
  logic [4:0]  r64_nm;

  mul_pipe_param #(.XLEN(32), .NUM_STAGES(8), .SQN_W(6), .TAG_W(6)) u32 (
    .clk(clk), .rst(rst), .en(en), .IN_wbStall(stall), .IN_branchTaken(br_taken),
    .IN_branchSqN(br_sqn), .IN_valid(v32), .IN_op(op), .IN_word(1'b0),
    .IN_srcA(a[31:0]), .IN_srcB(b[31:0]), .IN_tagDst(tag), .IN_nmDst(nm), .IN_sqN(sqn),
    .OUT_ready(r32_ready), .OUT_wbReq(r32_wbreq), .OUT_valid(r32_valid),
    .OUT_result(r32_res), .OUT_tagDst(r32_tag), .OUT_nmDst(r32_nm), .OUT_sqN(r32_sqn));

  mul_pipe_param #(.XLEN(64), .NUM_STAGES(8), .SQN_W(6), .TAG_W(6)) u64 (
    .clk(clk), .rst(rst), .en(en), .IN_wbStall(stall), .IN_branchTaken(br_taken),
    .IN_branchSqN(br_sqn), .IN_valid(v64), .IN_op(op), .IN_word(word),
    .IN_srcA(a), .IN_srcB(b), .IN_tagDst(tag), .IN_nmDst(nm), .IN_sqN(sqn),
    .OUT_ready(r64_ready), .OUT_wbReq(r64_wbreq), .OUT_valid(r64_valid),
    .OUT_result(r64_res), .OUT_tagDst(r64_tag), .OUT_nmDst(r64_nm), .OUT_sqN(r64_sqn));

  typedef struct { logic [63:0] res; logic [5:0] sqn; int cyc; } rec_t;
  rec_t q32[$];
  rec_t q64[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // A result is consumed when presented valid and the writeback port is not stalled.
  always @(negedge clk) begin
    rec_t r;
    if (r32_valid && !stall) begin
      r.res = 64'(r32_res); r.sqn = r32_sqn; r.cyc = cyc; q32.push_back(r);
    end
    if (r64_valid && !stall) begin
      r.res = r64_res; r.sqn = r64_sqn; r.cyc = cyc; q64.push_back(r);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_q(input bit is64, input int n, input int max);
    int k = 0;
    while (((is64 ? q64.size() : q32.size()) < n) && k < max) begin
      tick(1);
      k++;
    end
  endtask

  task automatic issue(input bit is64, input logic [1:0] o, input logic w, input logic [63:0] x,
                       input logic [63:0] y, input logic [5:0] s, output int t);
    op = o; word = w; a = x; b = y; sqn = s; tag = s; nm = 5'(s);
    v32 = !is64; v64 = is64;
    @(posedge clk);
    #1;
    t = cyc;
    v32 = 1'b0; v64 = 1'b0;
  endtask

  typedef struct { bit is64; logic [1:0] op; logic word; logic [63:0] a, b, exp; } vec_t;
  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic flush_case(input logic [5:0] s0, input logic [5:0] brs);
    int t;
    q32.delete();
    for (int k = 0; k < 3; k++) issue(1'b0, 2'd0, 1'b0, 64'd2, 64'd3, 6'(s0 + 6'(k)), t);
    tick(2);
    br_taken = 1'b1; br_sqn = brs;
    tick(1);
    br_taken = 1'b0;
    wait_q(1'b0, 2, 20);
    tick(12);
    check($sformatf("flush%0d count", brs), 64'(q32.size()), 64'd2);
    for (int k = 0; k < q32.size(); k++)
      check($sformatf("flush%0d sqn", brs), 64'(q32[k].sqn), 64'(6'(s0 + 6'(k))));
  endtask

  initial begin
    int t, t0, i, c;
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 64'h7,         64'hFFFFFFFD, 64'hFFFFFFEB};
    vecs[1]  = '{1'b0, 2'd1, 1'b0, 64'h80000000,  64'h80000000, 64'h40000000};
    vecs[2]  = '{1'b0, 2'd2, 1'b0, 64'hFFFFFFFF,  64'hFFFFFFFF, 64'hFFFFFFFF};
    vecs[3]  = '{1'b0, 2'd3, 1'b0, 64'hFFFFFFFF,  64'hFFFFFFFF, 64'hFFFFFFFE};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 64'h80000000,  64'hFFFFFFFF, 64'h80000000};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 64'h12345678,  64'h10,       64'h1};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 64'hFFFFFFFF,  64'hFFFFFFFF, 64'h0};
    vecs[7]  = '{1'b0, 2'd3, 1'b0, 64'h80000000,  64'h2,        64'h1};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 64'h7FFFFFFF,  64'h80000000, 64'hC0000000};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 64'h80000000,  64'h80000000, 64'hC0000000};
    vecs[10] = '{1'b0, 2'd0, 1'b0, 64'h0000FFFF,  64'h0000FFFF, 64'hFFFE0001};
    vecs[11] = '{1'b1, 2'd0, 1'b1, 64'h40000000,  64'h4,        64'h0};
    vecs[12] = '{1'b1, 2'd0, 1'b1, 64'h7FFFFFFF,  64'h2,        64'hFFFFFFFF_FFFFFFFE};
    vecs[13] = '{1'b1, 2'd0, 1'b1, 64'hFFFF0000_00000003, 64'h12345678_FFFFFFFF,
                 64'hFFFFFFFF_FFFFFFFD};
    vecs[14] = '{1'b1, 2'd1, 1'b0, 64'h80000000_00000000, 64'h80000000_00000000,
                 64'h40000000_00000000};
    vecs[15] = '{1'b1, 2'd3, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h2, 64'h1};
    vecs[16] = '{1'b1, 2'd0, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h5, 64'hFFFFFFFF_FFFFFFFB};
    vecs[17] = '{1'b1, 2'd0, 1'b0, 64'h1_00000000, 64'h1_00000000, 64'h0};

    rst = 1'b0; en = 1'b1; stall = 1'b0; br_taken = 1'b0; br_sqn = '0;
    v32 = 1'b0; v64 = 1'b0; word = 1'b0; op = '0; a = '0; b = '0; tag = '0; nm = '0; sqn = '0;
    tick(3);
    check("reset valid32", 64'(r32_valid), 64'd0);
    check("reset result32", 64'(r32_res), 64'd0);
    check("reset sqn32", 64'(r32_sqn), 64'd0);
    check("reset wbreq32", 64'(r32_wbreq), 64'd0);
    check("reset valid64", 64'(r64_valid), 64'd0);
    check("reset ready32", 64'(r32_ready), 64'd1);
    rst = 1'b1;
    tick(2);

    for (int k = 0; k < NV; k++) begin
      rec_t got[$];
      q32.delete(); q64.delete();
      issue(vecs[k].is64, vecs[k].op, vecs[k].word, vecs[k].a, vecs[k].b, 6'(k), t);
      wait_q(vecs[k].is64, 1, 20);
      tick(3);
      if (vecs[k].is64) got = q64; else got = q32;
      check($sformatf("vec%0d count", k), 64'(got.size()), 64'd1);
      if (got.size() > 0) begin
        check($sformatf("vec%0d result", k), got[0].res, vecs[k].exp);
        check($sformatf("vec%0d latency", k), 64'(got[0].cyc - t), 64'd9);
        check($sformatf("vec%0d sqn", k), 64'(got[0].sqn), 64'(6'(k)));
      end
    end

    // Eight back-to-back ops with a three-cycle stall in the middle of issue.
    q32.delete(); i = 0; c = 0; t0 = 0;
    while (i < 8 && c < 30) begin
      stall = (c >= 3 && c < 6);
      op = 2'd0; word = 1'b0; a = 64'(i + 1); b = 64'd3; sqn = 6'(10 + i); tag = sqn; nm = 5'(i);
      v32 = 1'b1;
      #1;
      check("stall ready", 64'(r32_ready), 64'(!stall));
      @(posedge clk);
      #1;
      if (!stall) begin
        if (i == 0) t0 = cyc;
        i++;
      end
      c++;
    end
    v32 = 1'b0; stall = 1'b0;
    wait_q(1'b0, 8, 40);
    tick(3);
    check("stall count", 64'(q32.size()), 64'd8);
    for (int k = 0; k < q32.size(); k++) begin
      check($sformatf("stall res%0d", k), q32[k].res, 64'(3 * (k + 1)));
      check($sformatf("stall sqn%0d", k), 64'(q32[k].sqn), 64'(10 + k));
    end
    if (q32.size() == 8) check("stall last cycle", 64'(q32[7].cyc - t0), 64'd19);

    flush_case(6'd5, 6'd6);
    flush_case(6'd62, 6'd63);

    // Flush on the accept cycle: the incoming op is tested too.
    q32.delete();
    br_taken = 1'b1; br_sqn = 6'd6;
    issue(1'b0, 2'd0, 1'b0, 64'd4, 64'd4, 6'd8, t);
    br_taken = 1'b0;
    issue(1'b0, 2'd0, 1'b0, 64'd4, 64'd5, 6'd9, t);
    br_taken = 1'b1; br_sqn = 6'd10;
    issue(1'b0, 2'd0, 1'b0, 64'd4, 64'd6, 6'd10, t);
    br_taken = 1'b0;
    wait_q(1'b0, 2, 20);
    tick(12);
    check("accflush count", 64'(q32.size()), 64'd2);
    if (q32.size() > 0) check("accflush first sqn", 64'(q32[0].sqn), 64'd9);
    if (q32.size() > 1) check("accflush second res", q32[1].res, 64'd24);

    // Flush while stalled clears valid bits without moving data.
    q32.delete();
    issue(1'b0, 2'd0, 1'b0, 64'd7, 64'd7, 6'd20, t);
    issue(1'b0, 2'd0, 1'b0, 64'd8, 64'd8, 6'd21, t);
    tick(1);
    stall = 1'b1;
    br_taken = 1'b1; br_sqn = 6'd20;
    tick(1);
    br_taken = 1'b0;
    tick(2);
    stall = 1'b0;
    wait_q(1'b0, 1, 20);
    tick(12);
    check("stallflush count", 64'(q32.size()), 64'd1);
    if (q32.size() > 0) check("stallflush res", q32[0].res, 64'd49);

    // Unit disabled: valid ignored.
    q32.delete();
    en = 1'b0;
    issue(1'b0, 2'd0, 1'b0, 64'd3, 64'd3, 6'd40, t);
    en = 1'b1;
    tick(14);
    check("disabled count", 64'(q32.size()), 64'd0);

    // Asynchronous reset mid-cycle with results streaming out.
    q32.delete();
    for (int k = 0; k < 11; k++) issue(1'b0, 2'd0, 1'b0, 64'(k + 1), 64'd5, 6'(30 + k), t);
    check("prereset valid", 64'(r32_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async rst valid", 64'(r32_valid), 64'd0);
    check("async rst result", 64'(r32_res), 64'd0);
    check("async rst wbreq", 64'(r32_wbreq), 64'd0);
    tick(2);
    #3;
    rst = 1'b1;
    q32.delete();
    tick(20);
    check("post reset count", 64'(q32.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
